// File: rtl/motor_pwm_pkg.sv
// motor_pwm_pkg: shared definitions for the dual-channel motor PWM driver.
//   ch_state_e  - channel state encoding (IDLE=0, RUN=1, DEAD=2)
//   EN/DIR/SPD  - bit positions inside a 3-bit motor command word
//   clamp_duty  - limits a duty constant to the PWM period
//   ramp_toward - one ramp step toward a target without overshooting it
package motor_pwm_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } ch_state_e;
    localparam int EN  = 2;
    localparam int DIR = 1;
    localparam int SPD = 0;
    function automatic int clamp_duty(input int duty, input int period);
        return duty > period ? period : duty;
    endfunction
    function automatic int ramp_toward(input int cur, input int tgt, input int step);
        return cur < tgt ? (tgt - cur > step ? cur + step : tgt)
                         : (cur - tgt > step ? cur - step : tgt);
    endfunction
endpackage

// File: rtl/motor_channel.sv
// motor_channel: one H-bridge channel -- PWM counter, duty ramp, IDLE/RUN/DEAD FSM.
//   clk_i, rst_i    - system clock, synchronous active-high reset
//   cmd_i[2:0]      - registered command {enable, dir (1=forward), speed (1=high)}
//   prox_i          - synchronized obstacle flag; stops forward motion only
//   ina_o/inb_o     - bridge forward/reverse enables, never both high
//   pwm_o           - high while counter < current duty
//   state_o[1:0]    - current channel state
module motor_channel
    import motor_pwm_pkg::*;
#(
    parameter int PWM_PERIOD       = 2500,
    parameter int DUTY_HI          = 2250,
    parameter int DUTY_LO          = 1250,
    parameter int RAMP_STEP        = 25,
    parameter int DEADTIME_PERIODS = 20
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] cmd_i,
    input  logic       prox_i,
    output logic       ina_o,
    output logic       inb_o,
    output logic       pwm_o,
    output logic [1:0] state_o
);
    localparam int W    = $clog2(PWM_PERIOD + 1);
    localparam int DW   = DEADTIME_PERIODS > 1 ? $clog2(DEADTIME_PERIODS) : 1;
    localparam int HI   = clamp_duty(DUTY_HI, PWM_PERIOD);
    localparam int LO   = clamp_duty(DUTY_LO, PWM_PERIOD);
    localparam int STEP = clamp_duty(RAMP_STEP, PWM_PERIOD);

    ch_state_e     state_q, state_d;
    logic [W-1:0]  cnt_q, cnt_d, duty_q, duty_d, tgt, ramped;
    logic [DW-1:0] dead_q, dead_d;
    logic          dir_q, dir_d, wrap, rev, stop;

    assign wrap   = cnt_q == W'(PWM_PERIOD - 1);
    assign cnt_d  = wrap ? '0 : cnt_q + 1'b1;
    // a direction change while running ramps down to zero before coasting
    assign rev    = state_q == RUN && cmd_i[DIR] != dir_q;
    assign stop   = !cmd_i[EN] || (prox_i && dir_q);
    assign tgt    = (!cmd_i[EN] || rev) ? '0 : (cmd_i[SPD] ? W'(HI) : W'(LO));
    assign ramped = W'(ramp_toward(int'(duty_q), int'(tgt), STEP));

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        dead_d  = dead_q;
        case (state_q)
            IDLE: begin
                duty_d = '0;
                if (wrap && cmd_i[EN] && !(cmd_i[DIR] && prox_i)) begin
                    state_d = RUN;
                    dir_d   = cmd_i[DIR];
                    duty_d  = ramped;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DEAD;
                    duty_d  = '0;
                    dead_d  = '0;
                end else if (wrap) begin
                    duty_d  = ramped;
                    state_d = (rev && ramped == '0) ? DEAD : RUN;
                end
            end
            DEAD: begin
                duty_d = '0;
                if (wrap) begin
                    dead_d  = (dead_q == DW'(DEADTIME_PERIODS - 1)) ? '0 : dead_q + 1'b1;
                    state_d = (dead_q == DW'(DEADTIME_PERIODS - 1)) ? IDLE : DEAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            duty_q  <= '0;
            dead_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            dead_q  <= dead_d;
            dir_q   <= dir_d;
        end
    end

    assign ina_o   = state_q == RUN && dir_q;
    assign inb_o   = state_q == RUN && !dir_q;
    assign pwm_o   = state_q == RUN && cnt_q < duty_q;
    assign state_o = state_q;
endmodule

// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: two independent H-bridge PWM channels with ramping and dead time.
//   clk_clk, reset_reset          - system clock, synchronous active-high reset
//   motor_l_cmd/motor_r_cmd[2:0]  - {enable, dir (1=forward), speed (1=high)}
//   prox_stop                     - asynchronous obstacle sensor, halts forward motion
//   motor_x_ina/inb/pwm           - per-side bridge forward, reverse and PWM drive
//   motor_x_state[1:0]            - per-side state: 0 IDLE, 1 RUN, 2 DEAD
module motor_pwm_driver
    import motor_pwm_pkg::*;
#(
    parameter int PWM_PERIOD       = 2500,
    parameter int DUTY_HI          = 2250,
    parameter int DUTY_LO          = 1250,
    parameter int RAMP_STEP        = 25,
    parameter int DEADTIME_PERIODS = 20
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [2:0] motor_l_cmd,
    input  logic [2:0] motor_r_cmd,
    input  logic       prox_stop,
    output logic       motor_l_ina,
    output logic       motor_l_inb,
    output logic       motor_l_pwm,
    output logic       motor_r_ina,
    output logic       motor_r_inb,
    output logic       motor_r_pwm,
    output logic [1:0] motor_l_state,
    output logic [1:0] motor_r_state
);
    logic [2:0] cmd_l_q, cmd_r_q;
    logic [1:0] prox_q;

    // prox_q[1] is the synchronized sensor; prox_q[0] absorbs metastability
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cmd_l_q <= '0;
            cmd_r_q <= '0;
            prox_q  <= '0;
        end else begin
            cmd_l_q <= motor_l_cmd;
            cmd_r_q <= motor_r_cmd;
            prox_q  <= {prox_q[0], prox_stop};
        end
    end

    motor_channel #(
        .PWM_PERIOD(PWM_PERIOD), .DUTY_HI(DUTY_HI), .DUTY_LO(DUTY_LO),
        .RAMP_STEP(RAMP_STEP), .DEADTIME_PERIODS(DEADTIME_PERIODS)
    ) u_left (
        .clk_i(clk_clk), .rst_i(reset_reset), .cmd_i(cmd_l_q), .prox_i(prox_q[1]),
        .ina_o(motor_l_ina), .inb_o(motor_l_inb), .pwm_o(motor_l_pwm), .state_o(motor_l_state)
    );

    motor_channel #(
        .PWM_PERIOD(PWM_PERIOD), .DUTY_HI(DUTY_HI), .DUTY_LO(DUTY_LO),
        .RAMP_STEP(RAMP_STEP), .DEADTIME_PERIODS(DEADTIME_PERIODS)
    ) u_right (
        .clk_i(clk_clk), .rst_i(reset_reset), .cmd_i(cmd_r_q), .prox_i(prox_q[1]),
        .ina_o(motor_r_ina), .inb_o(motor_r_inb), .pwm_o(motor_r_pwm), .state_o(motor_r_state)
    );
endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver: directed scenarios plus a randomized run against a behavioural model.
module tb_motor_pwm_driver;
    localparam int P = 10, HI = 8, LO = 4, STEP = 2, D = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] cmd_l, cmd_r;
    logic       prox;
    logic       l_ina, l_inb, l_pwm, r_ina, r_inb, r_pwm;
    logic [1:0] l_st, r_st;
    int         vectors = 0;
    int         errors  = 0;

    int         m_cnt[2], m_duty[2], m_st[2], m_dead[2];
    logic       m_dir[2];
    logic [2:0] m_cq[2];
    logic       m_p1, m_p2;

    always #5 clk = ~clk;

    motor_pwm_driver #(
        .PWM_PERIOD(P), .DUTY_HI(HI), .DUTY_LO(LO), .RAMP_STEP(STEP), .DEADTIME_PERIODS(D)
    ) dut (
        .clk_clk(clk), .reset_reset(rst), .motor_l_cmd(cmd_l), .motor_r_cmd(cmd_r),
        .prox_stop(prox),
        .motor_l_ina(l_ina), .motor_l_inb(l_inb), .motor_l_pwm(l_pwm),
        .motor_r_ina(r_ina), .motor_r_inb(r_inb), .motor_r_pwm(r_pwm),
        .motor_l_state(l_st), .motor_r_state(r_st)
    );

    function automatic int toward(input int cur, input int goal);
        int up, dn;
        up = cur + STEP < goal ? cur + STEP : goal;
        dn = cur - STEP > goal ? cur - STEP : goal;
        return cur < goal ? up : dn;
    endfunction

    // model state: 0 idle, 1 running, 2 coasting
    task automatic ch_step(input int c);
        logic en, dir, spd, wrap;
        int goal;
        en   = m_cq[c][2];
        dir  = m_cq[c][1];
        spd  = m_cq[c][0];
        wrap = m_cnt[c] == P - 1;
        goal = !en ? 0 : (spd ? HI : LO);
        if (m_st[c] == 0) begin
            if (wrap && en && !(dir && m_p2)) begin
                m_st[c] = 1; m_dir[c] = dir; m_duty[c] = toward(0, goal);
            end
        end else if (m_st[c] == 1) begin
            if (!en || (m_p2 && m_dir[c])) begin
                m_st[c] = 2; m_duty[c] = 0; m_dead[c] = 0;
            end else if (wrap) begin
                if (dir != m_dir[c]) begin
                    m_duty[c] = toward(m_duty[c], 0);
                    if (m_duty[c] == 0) begin m_st[c] = 2; m_dead[c] = 0; end
                end else m_duty[c] = toward(m_duty[c], goal);
            end
        end else if (wrap) begin
            m_dead[c]++;
            if (m_dead[c] == D) begin m_st[c] = 0; m_dead[c] = 0; end
        end
        m_cnt[c] = wrap ? 0 : m_cnt[c] + 1;
    endtask

    task automatic model_edge(input logic [2:0] cl, input logic [2:0] cr, input logic pr, input logic rs);
        if (rs) begin
            for (int c = 0; c < 2; c++) begin
                m_cnt[c] = 0; m_duty[c] = 0; m_st[c] = 0; m_dead[c] = 0; m_dir[c] = 1'b0; m_cq[c] = '0;
            end
            m_p1 = 1'b0; m_p2 = 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) ch_step(c);
            m_p2 = m_p1; m_p1 = pr; m_cq[0] = cl; m_cq[1] = cr;
        end
    endtask

    function automatic logic [4:0] exp_ch(input int c);
        logic run;
        run = m_st[c] == 1;
        return {2'(m_st[c]), run && m_dir[c], run && !m_dir[c], run && (m_cnt[c] < m_duty[c])};
    endfunction

    task automatic tick();
        logic [2:0] cl, cr;
        logic pr, rs;
        cl = cmd_l; cr = cmd_r; pr = prox; rs = rst;
        @(posedge clk);
        model_edge(cl, cr, pr, rs);
        #1;
    endtask

    task automatic count_period(output int hl, output int hr);
        hl = 0; hr = 0;
        repeat (P) begin hl += int'(l_pwm); hr += int'(r_pwm); tick(); end
    endtask

    task automatic align();
        int n = 0;
        while (m_cnt[0] != 0 && n < P) begin tick(); n++; end
    endtask

    task automatic wait_left_run(output int n);
        n = 0;
        while (l_st !== 2'd1 && n < 10 * P) begin tick(); n++; end
    endtask

    task automatic restart(input logic [2:0] cl, input logic [2:0] cr);
        rst = 1'b1; prox = 1'b0; cmd_l = '0; cmd_r = '0;
        tick(); tick();
        rst = 1'b0; cmd_l = cl; cmd_r = cr;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_l = '0; cmd_r = '0; prox = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({l_ina, l_inb, l_pwm, l_st, r_ina, r_inb, r_pwm, r_st} !== 10'b0) begin
            errors++; $display("FAIL reset_hold: got %b want 0", {l_ina, l_inb, l_pwm, l_st, r_ina, r_inb, r_pwm, r_st});
        end
        rst = 1'b0; cmd_l = 3'b111;
        tick();
        vectors++;
        if ({l_ina, l_inb, l_pwm, l_st, r_ina, r_inb, r_pwm, r_st} !== 10'b0) begin
            errors++; $display("FAIL reset_release: got %b want 0", {l_ina, l_inb, l_pwm, l_st, r_ina, r_inb, r_pwm, r_st});
        end
    endtask

    task automatic test_ramp_up();
        int n, hl, hr;
        int want[5] = '{2, 4, 6, 8, 8};
        wait_left_run(n);
        vectors++;
        if (n != 9 || l_ina !== 1'b1 || l_inb !== 1'b0) begin
            errors++; $display("FAIL ramp_entry: waited %0d ina=%b inb=%b want 9 1 0", n, l_ina, l_inb);
        end
        for (int i = 0; i < 5; i++) begin
            count_period(hl, hr);
            vectors++;
            if (hl != want[i] || hr != 0) begin
                errors++; $display("FAIL ramp_up_period%0d: left %0d right %0d want %0d 0", i, hl, hr, want[i]);
            end
        end
    endtask

    task automatic test_reverse();
        int hl, hr, bad;
        int down[4] = '{8, 6, 4, 2};
        int up[4]   = '{2, 4, 6, 8};
        cmd_l = 3'b101;
        for (int i = 0; i < 4; i++) begin
            count_period(hl, hr);
            vectors++;
            if (hl != down[i]) begin
                errors++; $display("FAIL reverse_down%0d: got %0d want %0d", i, hl, down[i]);
            end
        end
        bad = 0;
        repeat (D * P) begin
            if (l_st !== 2'd2 || l_ina !== 1'b0 || l_inb !== 1'b0 || l_pwm !== 1'b0) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin errors++; $display("FAIL reverse_dead: %0d bad cycles want 0", bad); end
        bad = 0;
        repeat (P) begin
            if (l_st !== 2'd0) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin errors++; $display("FAIL reverse_idle: %0d bad cycles want 0", bad); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (l_st !== 2'd1 || l_inb !== 1'b1 || l_ina !== 1'b0) begin
                errors++; $display("FAIL reverse_run%0d: st=%0d ina=%b inb=%b want 1 0 1", i, l_st, l_ina, l_inb);
            end
            count_period(hl, hr);
            vectors++;
            if (hl != up[i]) begin
                errors++; $display("FAIL reverse_up%0d: got %0d want %0d", i, hl, up[i]);
            end
        end
    endtask

    task automatic test_prox();
        int n, hl, hr, lat;
        restart(3'b111, 3'b000);
        wait_left_run(n);
        repeat (4) count_period(hl, hr);
        vectors++;
        if (hl != 8) begin errors++; $display("FAIL prox_pre_duty: got %0d want 8", hl); end
        tick();
        prox = 1'b1;
        lat = 0;
        while (lat < 4 && !(l_st === 2'd2 && l_pwm === 1'b0)) begin tick(); lat++; end
        vectors++;
        if (l_st !== 2'd2 || l_pwm !== 1'b0 || l_ina !== 1'b0) begin
            errors++; $display("FAIL prox_stop: after %0d cycles st=%0d pwm=%b want 2 0", lat, l_st, l_pwm);
        end
        cmd_l = 3'b100;
        wait_left_run(n);
        vectors++;
        if (l_st !== 2'd1 || l_inb !== 1'b1 || l_ina !== 1'b0) begin
            errors++; $display("FAIL prox_reverse: st=%0d ina=%b inb=%b want 1 0 1", l_st, l_ina, l_inb);
        end
        prox = 1'b0;
    endtask

    task automatic test_enable_drop();
        int n, hl, hr;
        restart(3'b110, 3'b110);
        wait_left_run(n);
        repeat (2) count_period(hl, hr);
        vectors++;
        if (hl != 4 || hr != 4) begin errors++; $display("FAIL enable_pre: %0d %0d want 4 4", hl, hr); end
        tick();
        cmd_l = 3'b000;
        tick(); tick();
        vectors++;
        if (l_pwm !== 1'b0 || l_st !== 2'd2) begin
            errors++; $display("FAIL enable_drop: pwm=%b st=%0d want 0 2", l_pwm, l_st);
        end
        align();
        count_period(hl, hr);
        vectors++;
        if (hr != 4 || r_st !== 2'd1 || r_ina !== 1'b1) begin
            errors++; $display("FAIL enable_right: duty %0d st=%0d ina=%b want 4 1 1", hr, r_st, r_ina);
        end
    endtask

    task automatic test_reset_mid_run();
        vectors++;
        if (r_st !== 2'd1) begin errors++; $display("FAIL midrun_pre: st=%0d want 1", r_st); end
        rst = 1'b1;
        tick();
        vectors++;
        if ({l_ina, l_inb, l_pwm, l_st, r_ina, r_inb, r_pwm, r_st} !== 10'b0) begin
            errors++; $display("FAIL reset_midrun: got %b want 0", {l_ina, l_inb, l_pwm, l_st, r_ina, r_inb, r_pwm, r_st});
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int hold_l = 0, hold_r = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (hold_l == 0) begin cmd_l = 3'($urandom); hold_l = $urandom_range(5, 200); end else hold_l--;
            if (hold_r == 0) begin cmd_r = 3'($urandom); hold_r = $urandom_range(5, 200); end else hold_r--;
            if ($urandom_range(0, 99) == 0) prox = ~prox;
            rst = $urandom_range(0, 1999) == 0;
            tick();
            vectors++;
            if ({l_st, l_ina, l_inb, l_pwm} !== exp_ch(0)) begin
                errors++; $display("FAIL rand_left cycle %0d: got %b want %b", i, {l_st, l_ina, l_inb, l_pwm}, exp_ch(0));
            end
            vectors++;
            if ({r_st, r_ina, r_inb, r_pwm} !== exp_ch(1)) begin
                errors++; $display("FAIL rand_right cycle %0d: got %b want %b", i, {r_st, r_ina, r_inb, r_pwm}, exp_ch(1));
            end
            vectors++;
            if (((l_ina & l_inb) | (r_ina & r_inb)) !== 1'b0) begin
                errors++; $display("FAIL rand_shoot_through cycle %0d: l=%b%b r=%b%b want never 11", i, l_ina, l_inb, r_ina, r_inb);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_reverse();
        test_prox();
        test_enable_drop();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
